// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings,
// one-hot phase codes, branch condition codes and flag bit positions.
package instruction_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_P1     = 3'd1,
        ST_P2     = 3'd2,
        ST_P3     = 3'd3,
        ST_P4     = 3'd4,
        ST_P5     = 3'd5,
        ST_HALTED = 3'd6
    } seq_state_t;

    localparam logic [4:0] PHASE_NONE = 5'b00000;
    localparam logic [4:0] PHASE_P1   = 5'b00001;
    localparam logic [4:0] PHASE_P2   = 5'b00010;
    localparam logic [4:0] PHASE_P3   = 5'b00100;
    localparam logic [4:0] PHASE_P4   = 5'b01000;
    localparam logic [4:0] PHASE_P5   = 5'b10000;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Instruction-memory fetch bus: request/address out, data/ready back.
interface instruction_fetch_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               IMEM_REQ;
    logic [ADDR_W-1:0]  IMEM_ADDR;
    logic [INSTR_W-1:0] IMEM_RDATA;
    logic               IMEM_READY;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_RDATA,
        input  IMEM_READY
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_RDATA,
        output IMEM_READY
    );
endinterface

// File: rtl/instruction_fetch_sequencer_branch_resolver.sv
// Combinational branch decision from decoder branch controls and the ALU flags.
module branch_resolver
    import instruction_fetch_sequencer_pkg::*;
(
    input  logic       pc_load,
    input  logic [2:0] cond,
    input  logic       uncond,
    input  logic [3:0] flags,
    output logic       taken
);
    logic cond_ok_s;
    logic unused_carry_s;

    // No condition code consults the carry flag
    assign unused_carry_s = flags[FLAG_C];

    // Evaluate the conditional-branch predicate selected by cond
    always_comb begin
        cond_ok_s = 1'b0;
        case (cond)
            COND_BE:  cond_ok_s = flags[FLAG_Z];
            COND_BLT: cond_ok_s = flags[FLAG_S] ^ flags[FLAG_V];
            COND_BLE: cond_ok_s = flags[FLAG_Z] | (flags[FLAG_S] ^ flags[FLAG_V]);
            COND_BNE: cond_ok_s = ~flags[FLAG_Z];
            default:  cond_ok_s = 1'b0;
        endcase
    end

    assign taken = pc_load & (uncond | cond_ok_s);

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Owns PC and instruction register; steps the five-phase instruction sequence
// and fetches each instruction over the req/ready memory handshake.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          exec,
    instruction_fetch_sequencer_if.master imem,
    output logic [INSTR_W-1:0]            COMMAND,
    output logic [ADDR_W-1:0]             PC_NEXT,
    output logic [4:0]                    PHASE,
    input  logic                          PC_load,
    input  logic [2:0]                    cond,
    input  logic                          uncond,
    input  logic [3:0]                    FLAGS,
    input  logic [ADDR_W-1:0]             TARGET,
    input  logic                          HALT,
    output logic                          halted
);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    seq_state_t         state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_next_r;
    logic [INSTR_W-1:0] command_r;
    logic               req_r;
    logic [4:0]         phase_r;
    logic               halted_r;

    logic               taken_s;
    logic [ADDR_W-1:0]  pc_upd_s;

    branch_resolver u_branch_resolver (
        .pc_load (PC_load),
        .cond    (cond),
        .uncond  (uncond),
        .flags   (FLAGS),
        .taken   (taken_s)
    );

    // PC value committed at the end of P5 when the instruction is not a halt
    always_comb begin
        pc_upd_s = pc_r + PC_ONE;
        if (taken_s) begin
            pc_upd_s = TARGET;
        end else begin
            pc_upd_s = pc_r + PC_ONE;
        end
    end

    // Phase sequencer with PC, instruction register and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            pc_next_r <= RESET_PC + PC_ONE;
            command_r <= '0;
            req_r     <= 1'b0;
            phase_r   <= PHASE_NONE;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (exec) begin
                        state_r <= ST_P1;
                        req_r   <= 1'b1;
                        phase_r <= PHASE_P1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_P1: begin
                    // Data is latched only on the handshake edge; REQ holds otherwise
                    if (imem.IMEM_READY) begin
                        command_r <= imem.IMEM_RDATA;
                        state_r   <= ST_P2;
                        req_r     <= 1'b0;
                        phase_r   <= PHASE_P2;
                    end else begin
                        state_r <= ST_P1;
                    end
                end
                ST_P2: begin
                    state_r <= ST_P3;
                    phase_r <= PHASE_P3;
                end
                ST_P3: begin
                    state_r <= ST_P4;
                    phase_r <= PHASE_P4;
                end
                ST_P4: begin
                    state_r <= ST_P5;
                    phase_r <= PHASE_P5;
                end
                ST_P5: begin
                    if (HALT) begin
                        state_r  <= ST_HALTED;
                        phase_r  <= PHASE_NONE;
                        halted_r <= 1'b1;
                    end else begin
                        pc_r      <= pc_upd_s;
                        pc_next_r <= pc_upd_s + PC_ONE;
                        if (exec) begin
                            state_r <= ST_P1;
                            req_r   <= 1'b1;
                            phase_r <= PHASE_P1;
                        end else begin
                            state_r <= ST_IDLE;
                            phase_r <= PHASE_NONE;
                        end
                    end
                end
                ST_HALTED: begin
                    // exec must drop before a fresh run can begin
                    if (!exec) begin
                        state_r  <= ST_IDLE;
                        halted_r <= 1'b0;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    req_r    <= 1'b0;
                    phase_r  <= PHASE_NONE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem.IMEM_REQ  = req_r;
    assign imem.IMEM_ADDR = pc_r;
    assign COMMAND        = command_r;
    assign PC_NEXT        = pc_next_r;
    assign PHASE          = phase_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed self-checking bench for instruction_fetch_sequencer: fetch timing,
// wait states, branch conditions, PC wrap, halt/restart and async reset.
module tb_instruction_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        exec;
    logic        ready;
    logic [15:0] COMMAND;
    logic [15:0] PC_NEXT;
    logic [4:0]  PHASE;
    logic        PC_load;
    logic [2:0]  cond;
    logic        uncond;
    logic [3:0]  FLAGS;
    logic [15:0] TARGET;
    logic        HALT;
    logic        halted;

    int          n_checks;
    int          n_errors;
    logic [15:0] pc_model;

    instruction_fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) imem_if ();

    instruction_fetch_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .exec    (exec),
        .imem    (imem_if.master),
        .COMMAND (COMMAND),
        .PC_NEXT (PC_NEXT),
        .PHASE   (PHASE),
        .PC_load (PC_load),
        .cond    (cond),
        .uncond  (uncond),
        .FLAGS   (FLAGS),
        .TARGET  (TARGET),
        .HALT    (HALT),
        .halted  (halted)
    );

    // Instruction memory image: word 0 is fixed, the rest derive from the address
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        if (addr == 16'h0000) begin
            return 16'h1234;
        end else begin
            return addr ^ 16'h5A5A;
        end
    endfunction

    assign imem_if.IMEM_RDATA = mem_word(imem_if.IMEM_ADDR);
    assign imem_if.IMEM_READY = ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from P1 with zero wait; apply branch controls in P5
    task automatic run_branch(input string tag, input logic ld, input logic unc,
                              input logic [2:0] cd, input logic [3:0] fl,
                              input logic [15:0] tgt, input logic [15:0] exp_pc);
        logic [15:0] exp_next;
        exp_next = exp_pc + 16'd1;
        check_val({tag, "_addr_p1"}, 32'(imem_if.IMEM_ADDR), 32'(pc_model));
        tick();
        check_val({tag, "_p2"}, 32'(PHASE), 32'h02);
        check_val({tag, "_cmd"}, 32'(COMMAND), 32'(mem_word(pc_model)));
        tick();
        tick();
        tick();
        check_val({tag, "_p5"}, 32'(PHASE), 32'h10);
        PC_load = ld;
        uncond  = unc;
        cond    = cd;
        FLAGS   = fl;
        TARGET  = tgt;
        tick();
        check_val({tag, "_phase"}, 32'(PHASE), 32'h01);
        check_val({tag, "_pc"}, 32'(imem_if.IMEM_ADDR), 32'(exp_pc));
        check_val({tag, "_pcnext"}, 32'(PC_NEXT), 32'(exp_next));
        PC_load = 1'b0;
        uncond  = 1'b0;
        cond    = 3'b000;
        FLAGS   = 4'b0000;
        TARGET  = 16'h0000;
        pc_model = exp_pc;
    endtask

    initial begin
        int n;
        logic [4:0] exp_ph [5];
        exp_ph = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        exec = 1'b0;
        ready = 1'b1;
        PC_load = 1'b0;
        cond = 3'b000;
        uncond = 1'b0;
        FLAGS = 4'b0000;
        TARGET = 16'h0000;
        HALT = 1'b0;
        pc_model = 16'h0000;

        #3;
        check_val("rst_phase", 32'(PHASE), 32'h00);
        check_val("rst_req", 32'(imem_if.IMEM_REQ), 32'h0);
        check_val("rst_cmd", 32'(COMMAND), 32'h0);
        check_val("rst_halted", 32'(halted), 32'h0);
        check_val("rst_pc", 32'(imem_if.IMEM_ADDR), 32'h0);
        check_val("rst_pcnext", 32'(PC_NEXT), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // 1: zero-wait fetch, phase walk and cycles per instruction
        exec = 1'b1;
        tick();
        check_val("t1_p1", 32'(PHASE), 32'h01);
        check_val("t1_req", 32'(imem_if.IMEM_REQ), 32'h1);
        n = 0;
        do begin
            tick();
            if (n < 5) check_val("t1_phase", 32'(PHASE), 32'(exp_ph[n]));
            if (n == 0) check_val("t1_cmd", 32'(COMMAND), 32'h1234);
            if (n == 0) check_val("t1_req_p2", 32'(imem_if.IMEM_REQ), 32'h0);
            n++;
        end while (PHASE != 5'h01 && n < 20);
        check_val("t1_cycles", 32'(n), 32'd5);
        check_val("t1_pc", 32'(imem_if.IMEM_ADDR), 32'h1);
        pc_model = 16'h0001;

        // 2: three wait cycles in P1
        n = 0;
        ready = 1'b0;
        repeat (3) begin
            tick();
            n++;
            check_val("t2_req", 32'(imem_if.IMEM_REQ), 32'h1);
            check_val("t2_addr", 32'(imem_if.IMEM_ADDR), 32'h1);
            check_val("t2_cmd_hold", 32'(COMMAND), 32'h1234);
            check_val("t2_phase_p1", 32'(PHASE), 32'h01);
        end
        ready = 1'b1;
        tick();
        n++;
        check_val("t2_p2", 32'(PHASE), 32'h02);
        check_val("t2_cmd", 32'(COMMAND), 32'h5A5B);
        while (PHASE != 5'h01 && n < 30) begin
            tick();
            n++;
        end
        check_val("t2_cycles", 32'(n), 32'd8);
        check_val("t2_pc", 32'(imem_if.IMEM_ADDR), 32'h2);
        pc_model = 16'h0002;

        // 3: conditional branches, taken and not taken
        run_branch("be_t",    1'b1, 1'b0, 3'b000, 4'b0100, 16'h0040, 16'h0040);
        run_branch("be_nt",   1'b1, 1'b0, 3'b000, 4'b0000, 16'h0040, 16'h0041);
        run_branch("blt_t",   1'b1, 1'b0, 3'b001, 4'b1000, 16'h0080, 16'h0080);
        run_branch("blt_nt",  1'b1, 1'b0, 3'b001, 4'b1001, 16'h0080, 16'h0081);
        run_branch("ble_nt",  1'b1, 1'b0, 3'b010, 4'b0000, 16'h00C0, 16'h0082);
        run_branch("ble_t",   1'b1, 1'b0, 3'b010, 4'b0100, 16'h00C0, 16'h00C0);
        run_branch("bne_t",   1'b1, 1'b0, 3'b011, 4'b0000, 16'h0200, 16'h0200);
        run_branch("bne_nt",  1'b1, 1'b0, 3'b011, 4'b0100, 16'h0200, 16'h0201);
        run_branch("c100_nt", 1'b1, 1'b0, 3'b100, 4'b0100, 16'h0300, 16'h0202);
        run_branch("c111_nt", 1'b1, 1'b0, 3'b111, 4'b1111, 16'h0300, 16'h0203);
        run_branch("noload",  1'b0, 1'b0, 3'b000, 4'b0100, 16'h0400, 16'h0204);

        // 4: unconditional branch
        run_branch("uncond",  1'b1, 1'b1, 3'b100, 4'b0000, 16'h0100, 16'h0100);

        // 5: PC wrap, then halt and restart
        run_branch("to_ffff", 1'b1, 1'b1, 3'b000, 4'b0000, 16'hFFFF, 16'hFFFF);
        run_branch("wrap",    1'b0, 1'b0, 3'b000, 4'b0000, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        tick();
        HALT = 1'b1;
        tick();
        HALT = 1'b0;
        check_val("halt_flag", 32'(halted), 32'h1);
        check_val("halt_phase", 32'(PHASE), 32'h00);
        check_val("halt_pc", 32'(imem_if.IMEM_ADDR), 32'h0);
        repeat (3) begin
            tick();
            check_val("halt_hold", 32'(halted), 32'h1);
            check_val("halt_req", 32'(imem_if.IMEM_REQ), 32'h0);
        end
        exec = 1'b0;
        tick();
        check_val("halt_exit", 32'(halted), 32'h0);
        check_val("idle_phase", 32'(PHASE), 32'h00);
        exec = 1'b1;
        tick();
        check_val("restart_p1", 32'(PHASE), 32'h01);
        check_val("restart_req", 32'(imem_if.IMEM_REQ), 32'h1);
        check_val("restart_pc", 32'(imem_if.IMEM_ADDR), 32'h0);

        // 6: exec drop mid-instruction, then async reset in P3
        tick();
        tick();
        check_val("drop_p3", 32'(PHASE), 32'h04);
        exec = 1'b0;
        tick();
        tick();
        check_val("drop_p5", 32'(PHASE), 32'h10);
        tick();
        check_val("drop_idle", 32'(PHASE), 32'h00);
        check_val("drop_pc", 32'(imem_if.IMEM_ADDR), 32'h1);
        tick();
        check_val("drop_stay", 32'(PHASE), 32'h00);
        check_val("drop_req", 32'(imem_if.IMEM_REQ), 32'h0);
        exec = 1'b1;
        tick();
        tick();
        tick();
        check_val("arst_p3", 32'(PHASE), 32'h04);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_phase", 32'(PHASE), 32'h00);
        check_val("arst_pc", 32'(imem_if.IMEM_ADDR), 32'h0);
        check_val("arst_cmd", 32'(COMMAND), 32'h0);
        check_val("arst_req", 32'(imem_if.IMEM_REQ), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("post_rst_p1", 32'(PHASE), 32'h01);
        check_val("post_rst_pc", 32'(imem_if.IMEM_ADDR), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
